// File: rtl/cl_note_pkg.sv
// Shared definitions for note metadata words: field positions, tags, the decoded
// note record and the stream-reader FSM states.
package cl_note_pkg;

    localparam int TAG_HI   = 31;
    localparam int TAG_LO   = 29;
    localparam int PITCH_HI = 28;
    localparam int PITCH_LO = 23;
    localparam int STR_HI   = 22;
    localparam int STR_LO   = 20;
    localparam int FRET_HI  = 19;
    localparam int FRET_LO  = 16;
    localparam int TIME_HI  = 15;
    localparam int TIME_LO  = 0;

    localparam logic [2:0] TAG_NOTE = 3'b000;
    localparam logic [2:0] TAG_END  = 3'b111;

    typedef struct packed {
        logic [5:0]  pitch;
        logic [2:0]  strg;
        logic [3:0]  fret;
        logic [15:0] ntime;
    } note_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic [2:0] word_tag(input logic [31:0] w);
        return w[TAG_HI:TAG_LO];
    endfunction

    function automatic note_t decode_word(input logic [31:0] w);
        note_t n;
        n.pitch = w[PITCH_HI:PITCH_LO];
        n.strg  = w[STR_HI:STR_LO];
        n.fret  = w[FRET_HI:FRET_LO];
        n.ntime = w[TIME_HI:TIME_LO];
        return n;
    endfunction

endpackage

// File: rtl/cl_note_fifo.sv
// Small synchronous FIFO of decoded notes. A push while full is accepted when a pop
// happens in the same cycle; flush empties the buffer and wins over push/pop.
module cl_note_fifo
    import cl_note_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_push,
    input  note_t i_data,
    input  logic  i_pop,
    input  logic  i_flush,
    output note_t o_data,
    output logic  o_full,
    output logic  o_empty
);

    localparam int AW = $clog2(DEPTH);

    note_t          r_mem [DEPTH];
    logic  [AW:0]   r_wr;
    logic  [AW:0]   r_rd;
    logic           w_do_push;
    logic           w_do_pop;

    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_data  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else if (i_flush) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/cl_note_stream_reader.sv
// Playback reader: walks the note metadata BRAM from address 0, decodes note words into
// a FIFO and releases the head note once song time reaches its time minus LOOKAHEAD.
module cl_note_stream_reader
    import cl_note_pkg::*;
#(
    parameter int          LOGSIZE    = 12,
    parameter logic [15:0] LOOKAHEAD  = 16'd0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               loaded,
    input  logic [15:0]        song_time,
    output logic [LOGSIZE-1:0] mem_addr,
    input  logic [31:0]        mem_dout,
    output logic               note_valid,
    input  logic               note_ready,
    output logic [5:0]         note_pitch,
    output logic [2:0]         note_string,
    output logic [3:0]         note_fret,
    output logic [15:0]        note_time,
    output logic               busy,
    output logic               done
);

    state_t             r_state, w_next;
    logic [LOGSIZE-1:0] r_addr, w_addr_next;
    note_t              r_held;
    note_t              w_word, w_head, w_push_data;
    logic [2:0]         w_tag;
    logic               w_push, w_pop, w_flush, w_hold_load, w_advance;
    logic               w_full, w_empty, w_can_push, w_active;
    logic [16:0]        w_lhs, w_rhs;

    assign w_word     = decode_word(mem_dout);
    assign w_tag      = word_tag(mem_dout);
    assign w_active   = (r_state == ST_FETCH) || (r_state == ST_WAIT) ||
                        (r_state == ST_HOLD)  || (r_state == ST_DRAIN);
    assign w_can_push = !w_full || w_pop;

    always_comb begin
        w_next      = r_state;
        w_addr_next = r_addr;
        w_push      = 1'b0;
        w_push_data = w_word;
        w_flush     = 1'b0;
        w_hold_load = 1'b0;
        w_advance   = 1'b0;
        if (start && loaded) begin
            w_next      = ST_FETCH;
            w_addr_next = '0;
            w_flush     = 1'b1;
        end else if (w_active && !loaded) begin
            w_next      = ST_IDLE;
            w_addr_next = '0;
            w_flush     = 1'b1;
        end else begin
            case (r_state)
                ST_FETCH: w_next = ST_WAIT;
                ST_WAIT: begin
                    if (w_tag == TAG_NOTE) begin
                        if (w_can_push) begin
                            w_push    = 1'b1;
                            w_advance = 1'b1;
                        end else begin
                            w_hold_load = 1'b1;
                            w_next      = ST_HOLD;
                        end
                    end else if (w_tag == TAG_END) begin
                        w_next = ST_DRAIN;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
                ST_HOLD: begin
                    w_push_data = r_held;
                    if (w_can_push) begin
                        w_push    = 1'b1;
                        w_advance = 1'b1;
                    end
                end
                ST_DRAIN: if (w_empty) w_next = ST_DONE;
                default: ;
            endcase
            // Running off the top of the BRAM without an end word ends the song.
            if (w_advance) begin
                if (&r_addr) begin
                    w_next = ST_DRAIN;
                end else begin
                    w_addr_next = r_addr + LOGSIZE'(1);
                    w_next      = ST_FETCH;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_next;
            r_addr  <= w_addr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hold_load) r_held <= w_word;
    end

    cl_note_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // 17-bit compare so a late note near 0xFFFF never wraps into early release.
    assign w_lhs      = {1'b0, w_head.ntime};
    assign w_rhs      = {1'b0, song_time} + {1'b0, LOOKAHEAD};
    assign note_valid = !w_empty && (w_lhs <= w_rhs);
    assign w_pop      = note_valid && note_ready;

    assign note_pitch  = w_empty ? '0 : w_head.pitch;
    assign note_string = w_empty ? '0 : w_head.strg;
    assign note_fret   = w_empty ? '0 : w_head.fret;
    assign note_time   = w_empty ? '0 : w_head.ntime;

    assign mem_addr = r_addr;
    assign busy     = w_active;
    assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_cl_note_stream_reader.sv
// Scoreboard bench: stimulus queues expected notes, a negedge monitor pops and compares
// on each handshake of the main reader; a second reader with LOOKAHEAD=50 checks release timing.
module tb_cl_note_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        loaded = 1'b0;
    logic [15:0] song_time = '0;

    logic        start_a = 1'b0, ready_a = 1'b0;
    logic [11:0] addr_a;
    logic [31:0] dout_a = '0;
    logic        valid_a, busy_a, done_a;
    logic [5:0]  pitch_a;
    logic [2:0]  string_a;
    logic [3:0]  fret_a;
    logic [15:0] time_a;

    logic        start_b = 1'b0, ready_b = 1'b0;
    logic [11:0] addr_b;
    logic [31:0] dout_b = '0;
    logic        valid_b, busy_b, done_b;
    logic [5:0]  pitch_b;
    logic [2:0]  string_b;
    logic [3:0]  fret_b;
    logic [15:0] time_b;

    logic [31:0] mem_a [4096];
    logic [31:0] mem_b [4096];

    logic [28:0] exp_q [$];
    int          n_vec  = 0;
    int          n_fail = 0;
    int          n_pops = 0;

    localparam logic [31:0] END_W  = 32'hE000_0000;
    localparam logic [31:0] SKIP_W = 32'h4ABC_1234;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        dout_a <= mem_a[addr_a];
        dout_b <= mem_b[addr_b];
    end

    cl_note_stream_reader #(.LOGSIZE(12), .LOOKAHEAD(16'd0), .FIFO_DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start_a), .loaded(loaded), .song_time(song_time),
        .mem_addr(addr_a), .mem_dout(dout_a), .note_valid(valid_a), .note_ready(ready_a),
        .note_pitch(pitch_a), .note_string(string_a), .note_fret(fret_a), .note_time(time_a),
        .busy(busy_a), .done(done_a)
    );

    cl_note_stream_reader #(.LOGSIZE(12), .LOOKAHEAD(16'd50), .FIFO_DEPTH(2)) u_la (
        .clk(clk), .rst_n(rst_n), .start(start_b), .loaded(loaded), .song_time(song_time),
        .mem_addr(addr_b), .mem_dout(dout_b), .note_valid(valid_b), .note_ready(ready_b),
        .note_pitch(pitch_b), .note_string(string_b), .note_fret(fret_b), .note_time(time_b),
        .busy(busy_b), .done(done_b)
    );

    function automatic logic [31:0] mk_note(input logic [15:0] t, input logic [5:0] p,
                                            input logic [2:0] s, input logic [3:0] f);
        return {3'b000, p, s, f, t};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [15:0] t, input logic [5:0] p,
                            input logic [2:0] s, input logic [3:0] f);
        exp_q.push_back({p, s, f, t});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input string nm);
        int k;
        k = 0;
        while (!done_a && k < 2000) begin
            tick();
            k++;
        end
        check(nm, {31'd0, done_a}, 32'd1);
    endtask

    // Monitor: every handshake of the main reader must match the next queued note,
    // and a presented note must never be early (LOOKAHEAD is 0 on this instance).
    always @(negedge clk) begin
        if (rst_n && valid_a) begin
            n_vec++;
            if (time_a > song_time) begin
                n_fail++;
                $display("FAIL early_release: note_time %0d song_time %0d", time_a, song_time);
            end
            if (ready_a) begin
                n_pops++;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_note: got 0x%0h with empty scoreboard",
                             {pitch_a, string_a, fret_a, time_a});
                end else begin
                    logic [28:0] e;
                    e = exp_q.pop_front();
                    if ({pitch_a, string_a, fret_a, time_a} !== e) begin
                        n_fail++;
                        $display("FAIL note_fields: got 0x%0h expected 0x%0h",
                                 {pitch_a, string_a, fret_a, time_a}, e);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int i = 0; i < 4096; i++) begin
            mem_a[i] = END_W;
            mem_b[i] = END_W;
        end

        // Reset values
        #3;
        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_busy",  {31'd0, busy_a},  32'd0);
        check("rst_done",  {31'd0, done_a},  32'd0);
        check("rst_addr",  {20'd0, addr_a},  32'd0);
        check("rst_fields", {3'd0, pitch_a, string_a, fret_a, time_a}, 32'd0);
        tick();
        rst_n  = 1'b1;
        loaded = 1'b1;
        tick();

        // Two notes then end, song time ramps 0..300
        mem_a[0] = mk_note(16'd100, 6'd5, 3'd2, 4'd3);
        mem_a[1] = mk_note(16'd200, 6'd12, 3'd4, 4'd7);
        mem_a[2] = END_W;
        push_exp(16'd100, 6'd5, 3'd2, 4'd3);
        push_exp(16'd200, 6'd12, 3'd4, 4'd7);
        ready_a = 1'b1;
        song_time = 16'd0;
        pulse_start_a();
        for (int t = 1; t <= 300; t++) begin
            song_time = 16'(t);
            #1;
            if (t == 99)  check("t1_not_at_99",  {31'd0, valid_a}, 32'd0);
            if (t == 100) begin
                check("t1_valid_at_100", {31'd0, valid_a}, 32'd1);
                check("t1_fields", {3'd0, pitch_a, string_a, fret_a, time_a},
                      {3'd0, 6'd5, 3'd2, 4'd3, 16'd100});
            end
            if (t == 199) check("t1_not_at_199", {31'd0, valid_a}, 32'd0);
            if (t == 200) check("t1_valid_at_200", {31'd0, valid_a}, 32'd1);
            tick();
        end
        wait_done_a("t1_done");
        check("t1_busy_low", {31'd0, busy_a}, 32'd0);
        check("t1_addr_stop", {20'd0, addr_a}, 32'd2);
        check("t1_sb_empty", exp_q.size(), 32'd0);

        // Five notes at t=0 with consumer stalled: FIFO fills and the reader holds
        for (int i = 0; i < 5; i++) begin
            mem_a[i] = mk_note(16'd0, 6'(i + 1), 3'd1, 4'd1);
            push_exp(16'd0, 6'(i + 1), 3'd1, 4'd1);
        end
        mem_a[5] = END_W;
        ready_a = 1'b0;
        song_time = 16'd0;
        pulse_start_a();
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 6 || c == 13 || c == 20) begin
                check("t3_head_valid", {31'd0, valid_a}, 32'd1);
                check("t3_head_stable", {3'd0, pitch_a, string_a, fret_a, time_a},
                      {3'd0, 6'd1, 3'd1, 4'd1, 16'd0});
            end
        end
        check("t3_hold_addr", {20'd0, addr_a}, 32'd2);
        check("t3_hold_busy", {31'd0, busy_a}, 32'd1);
        base = n_pops;
        ready_a = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        check("t3_five_pops", n_pops - base, 32'd5);
        wait_done_a("t3_done");
        check("t3_sb_empty", exp_q.size(), 32'd0);

        // Skip word in the stream produces no output
        mem_a[0] = mk_note(16'd10, 6'd7, 3'd3, 4'd9);
        mem_a[1] = SKIP_W;
        mem_a[2] = mk_note(16'd20, 6'd8, 3'd4, 4'd10);
        mem_a[3] = END_W;
        push_exp(16'd10, 6'd7, 3'd3, 4'd9);
        push_exp(16'd20, 6'd8, 3'd4, 4'd10);
        base = n_pops;
        song_time = 16'd0;
        pulse_start_a();
        for (int t = 1; t <= 30; t++) begin
            song_time = 16'(t);
            tick();
        end
        wait_done_a("t4_done");
        check("t4_two_notes", n_pops - base, 32'd2);
        check("t4_addr_stop", {20'd0, addr_a}, 32'd3);

        // Restart mid-stream after two notes
        for (int i = 0; i < 4; i++) mem_a[i] = mk_note(16'd0, 6'(10 + i), 3'd2, 4'd5);
        mem_a[4] = END_W;
        push_exp(16'd0, 6'd10, 3'd2, 4'd5);
        push_exp(16'd0, 6'd11, 3'd2, 4'd5);
        base = n_pops;
        song_time = 16'd0;
        pulse_start_a();
        for (int c = 0; c < 40 && (n_pops - base) < 2; c++) tick();
        check("t6_two_before_abort", n_pops - base, 32'd2);
        start_a = 1'b1;
        ready_a = 1'b0;
        tick();
        start_a = 1'b0;
        check("t6_valid_low_after_abort", {31'd0, valid_a}, 32'd0);
        check("t6_addr_rewound", {20'd0, addr_a}, 32'd0);
        check("t6_busy", {31'd0, busy_a}, 32'd1);
        for (int i = 0; i < 4; i++) push_exp(16'd0, 6'(10 + i), 3'd2, 4'd5);
        base = n_pops;
        ready_a = 1'b1;
        wait_done_a("t6_replay_done");
        check("t6_replay_pops", n_pops - base, 32'd4);
        check("t6_sb_empty", exp_q.size(), 32'd0);

        // Asynchronous reset while waiting on BRAM data
        ready_a = 1'b0;
        pulse_start_a();
        tick();
        check("t6_busy_in_wait", {31'd0, busy_a}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy",  {31'd0, busy_a},  32'd0);
        check("t6_rst_done",  {31'd0, done_a},  32'd0);
        check("t6_rst_valid", {31'd0, valid_a}, 32'd0);
        check("t6_rst_addr",  {20'd0, addr_a},  32'd0);
        exp_q.delete();
        rst_n = 1'b1;
        tick();

        // Dropping loaded mid-play returns to idle
        pulse_start_a();
        check("ld_busy_on", {31'd0, busy_a}, 32'd1);
        loaded = 1'b0;
        tick();
        check("ld_busy_off", {31'd0, busy_a}, 32'd0);
        check("ld_done_off", {31'd0, done_a}, 32'd0);
        check("ld_valid_off", {31'd0, valid_a}, 32'd0);
        loaded = 1'b1;
        tick();

        // LOOKAHEAD=50 instance: early release and the no-wrap compare
        mem_b[0] = mk_note(16'd100, 6'd9, 3'd1, 4'd2);
        mem_b[1] = mk_note(16'hFFFF, 6'd33, 3'd5, 4'd7);
        mem_b[2] = END_W;
        song_time = 16'd0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        song_time = 16'd49;
        #1;
        check("la_not_at_49", {31'd0, valid_b}, 32'd0);
        song_time = 16'd50;
        #1;
        check("la_valid_at_50", {31'd0, valid_b}, 32'd1);
        check("la_time_100", {16'd0, time_b}, 32'd100);
        ready_b = 1'b1;
        tick();
        ready_b = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        song_time = 16'h0005;
        #1;
        check("la_no_wrap_0005", {31'd0, valid_b}, 32'd0);
        song_time = 16'hFFCC;
        #1;
        check("la_not_at_FFCC", {31'd0, valid_b}, 32'd0);
        song_time = 16'hFFCD;
        #1;
        check("la_valid_at_FFCD", {31'd0, valid_b}, 32'd1);
        check("la_time_FFFF", {16'd0, time_b}, 32'h0000_FFFF);
        song_time = 16'hFFFF;
        #1;
        check("la_valid_at_FFFF", {31'd0, valid_b}, 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
